cpu_boot_loader: RTL and testbench

//  Upstream bring-up stage for the multicycle CPU. Streams a program image into

---
 rtl/cpu_boot_loader_pkg.sv | 30 +++
 rtl/cpu_boot_loader_if.sv | 33 +++
 rtl/cpu_boot_loader_run_timer.sv | 37 +++
 rtl/cpu_boot_loader.sv | 125 ++++++++++++
 tb/tb_cpu_boot_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_boot_loader_pkg.sv
// Shared state encoding, address step and sizing for the CPU boot loader.
// The enum values alias the 3-bit state codes so both forms stay consistent.
package cpu_boot_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_FLUSH = ST_FLUSH,
        S_RUN   = ST_RUN,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_e;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam int unsigned WC_W      = 16;

    // Byte address of word idx; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [WC_W-1:0] idx);
        return base + ({{(32-WC_W){1'b0}}, idx} * ADDR_STEP);
    endfunction

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Bundle of the boot loader's host stream, memory write port and CPU run gate.
// master = host/test side, slave = the loader itself.
interface cpu_boot_loader_if;
    import cpu_boot_pkg::*;

    logic              start;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_din;
    logic              cpu_run;
    logic [31:0]       v1_in;
    logic [31:0]       result;
    logic              done;
    logic              error;
    logic [WC_W-1:0]   word_count;

    modport master (
        output start, in_valid, in_data, in_last, v1_in,
        input  in_ready, mem_we, mem_addr, mem_din, cpu_run,
               result, done, error, word_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last, v1_in,
        output in_ready, mem_we, mem_addr, mem_din, cpu_run,
               result, done, error, word_count
    );

endinterface

// File: rtl/cpu_boot_loader_run_timer.sv
// Run-phase cycle counter: held at zero while cleared, counts while enabled,
// and flags the last cycle of a RUN_CYCLES-long window.
module run_timer #(
    parameter int unsigned RUN_CYCLES = 1350
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [31:0] TERMINAL = 32'(RUN_CYCLES - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 32'd0;
        end else if (en_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == TERMINAL);

endmodule

// File: rtl/cpu_boot_loader.sv
// Streams a program image into DataMemory, then gates the CPU on for a fixed
// number of clocks and captures register v1 as the program result.
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR   = 32'h0,
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter int unsigned  RUN_CYCLES  = 1350
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_boot_loader_if.slave  bus
);

    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(DEPTH_WORDS - 1);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   word_count_q, word_count_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [31:0]       result_q, result_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              in_ready;
    logic              accept;
    logic              run_tc;

    assign in_ready = (state_q == S_LOAD);
    assign accept   = bus.in_valid && in_ready;

    run_timer #(
        .RUN_CYCLES (RUN_CYCLES)
    ) u_run_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q != S_RUN),
        .en_i    (state_q == S_RUN),
        .tc_o    (run_tc)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        result_d     = result_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_addr(BASE_ADDR, word_count_q);
                    mem_din_d    = bus.in_data;
                    word_count_d = word_count_q + 1'b1;
                    // A final word at the last slot is legal; only a missing in_last overflows.
                    if (bus.in_last) begin
                        state_d = S_FLUSH;
                    end else if (word_count_q == LAST_IDX) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (run_tc) begin
                    result_d = bus.v1_in;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            result_q     <= 32'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            result_q     <= result_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.cpu_run    = (state_q == S_RUN);
    assign bus.result     = result_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: the driver predicts writes, run starts
// and results from the image rules; a negedge monitor pops and compares them.
module tb_cpu_boot_loader;

    localparam int          DEPTH = 4;
    localparam int          RUNC  = 8;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_boot_loader_if bus();

    cpu_boot_loader #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .RUN_CYCLES  (RUNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          vectors     = 0;
    int          miscompares = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_res[$];
    int          exp_run_at[$];
    int          neg_cyc   = 0;
    int          run_len   = 0;
    logic        run_prev  = 1'b0;
    logic        done_prev = 1'b0;
    wr_t         mon_w;
    logic [31:0] mon_r;
    int          mon_t;
    logic [31:0] img[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT write, run start, run length and result is compared here.
    always @(negedge clk) begin
        neg_cyc++;
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.mem_addr, bus.mem_din);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_addr, mon_w.addr);
                    chk("wr_data", bus.mem_din, mon_w.data);
                end
            end
            if (bus.cpu_run && !run_prev) begin
                if (exp_run_at.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_run: cpu_run rose at cycle %0d, expected no run", neg_cyc);
                end else begin
                    mon_t = exp_run_at.pop_front();
                    chk("run_latency", 32'(neg_cyc), 32'(mon_t + 2));
                end
            end
            if (bus.cpu_run) begin
                run_len++;
            end else if (run_prev) begin
                chk("run_len", 32'(run_len), 32'(RUNC));
                run_len = 0;
            end
            if (bus.done && !done_prev) begin
                if (exp_res.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: result %h, expected no done", bus.result);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("result", bus.result, mon_r);
                end
            end
        end
        run_prev  = bus.cpu_run;
        done_prev = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready",   32'(bus.in_ready),   32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,        32'd0);
        chk("rst_mem_din",    bus.mem_din,         32'd0);
        chk("rst_cpu_run",    32'(bus.cpu_run),    32'd0);
        chk("rst_result",     bus.result,          32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_error",      32'(bus.error),      32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
    endtask

    // Feeds img[0..n-1]. Model: words are written at BASE+4*k until in_last or
    // until DEPTH words without in_last (overflow); later words are refused.
    // bubble: 0 none, 1 one idle cycle between words, 2 random 0..2 idle cycles.
    task automatic load_image(input int n, input bit has_last, input int bubble,
                              input logic [31:0] v1, input bit poke_start);
        int acc   = 0;
        bit ended = 0;
        bit err   = 0;
        bit fin   = 0;
        bus.v1_in = v1;
        do_start();
        chk("start_done_clr",  32'(bus.done),       32'd0);
        chk("start_error_clr", 32'(bus.error),      32'd0);
        chk("start_wc_clr",    32'(bus.word_count), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (bubble == 1 && i > 0) tick();
            if (bubble == 2) repeat ($urandom_range(0, 2)) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            bus.in_last  = has_last && (i == n - 1);
            chk("in_ready", 32'(bus.in_ready), 32'(!ended));
            fin = 0;
            if (!ended) begin
                exp_wr.push_back('{BASE + 32'(acc) * 4, img[i]});
                acc++;
                if (bus.in_last) begin
                    ended = 1;
                    fin   = 1;
                    exp_res.push_back(v1);
                end else if (acc == DEPTH) begin
                    ended = 1;
                    err   = 1;
                end
            end
            tick();
            if (fin) exp_run_at.push_back(neg_cyc);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        if (err) begin
            tick();
            tick();
            chk("err_flag",     32'(bus.error),    32'd1);
            chk("err_in_ready", 32'(bus.in_ready), 32'd0);
            chk("err_done",     32'(bus.done),     32'd0);
        end else if (ended) begin
            if (poke_start) begin
                repeat (4) tick();
                do_start();
            end
            for (int k = 0; k < RUNC + 20 && bus.done !== 1'b1; k++) tick();
            chk("done", 32'(bus.done), 32'd1);
        end else begin
            tick();
            tick();
        end
        chk("word_count", 32'(bus.word_count), 32'(acc));
        repeat (2) tick();
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;
        bus.v1_in    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // in_valid while IDLE is ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        // Reset mid-load after three words, then a fresh load from BASE.
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        load_image(3, 1'b0, 0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();

        img[0] = 32'h2002_0005;
        img[1] = 32'h2003_0007;
        img[2] = 32'h0043_1020;
        img[3] = 32'h0000_0000;
        load_image(4, 1'b1, 0, 32'd58, 1'b0);
        load_image(4, 1'b1, 1, 32'd77, 1'b0);
        img[0] = 32'h1234_5678;
        load_image(1, 1'b1, 0, 32'hCAFE_0001, 1'b0);
        for (int i = 0; i < 5; i++) img[i] = $urandom;
        load_image(5, 1'b0, 0, 32'd0, 1'b0);
        load_image(2, 1'b1, 0, 32'h0000_00AA, 1'b1);

        for (int it = 0; it < 20; it++) begin
            int  n;
            bit  hl;
            n  = $urandom_range(1, 6);
            hl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            load_image(n, hl, 2, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) tick();
        chk("results_drained", 32'(exp_res.size()), 32'd0);
        chk("runs_drained",    32'(exp_run_at.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
